// File: rtl/dmem_arb_pkg.sv
// ---------------------------------------------------------------------------
// dmem_arb_pkg
// Shared types and default widths for the data-memory arbiter slice.
//   arb_state_e  : host-transaction FSM state (IDLE, ACK)
//   DEF_ADDR_W   : default address width of all arbiter ports
//   DEF_DATA_W   : default data width of all arbiter ports
// ---------------------------------------------------------------------------
package dmem_arb_pkg;

   localparam int DEF_ADDR_W = 32;
   localparam int DEF_DATA_W = 32;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      ACK  = 1'b1
   } arb_state_e;

endpackage

// File: rtl/dmem_arb_starve_cnt.sv
// ---------------------------------------------------------------------------
// dmem_arb_starve_cnt
// Saturating wait counter for the host starvation guard. It counts the
// cycles a host request has been refused and flags when the limit is met.
// Ports:
//   clk        in   clock, rising edge
//   reset      in   asynchronous active-high reset, clears the count
//   inc        in   host refused this cycle: count up (saturates at LIMIT)
//   clr        in   host granted or no request: clear (wins over inc)
//   limit_hit  out  count has reached LIMIT; host must be forced in
// ---------------------------------------------------------------------------
module dmem_arb_starve_cnt #(
   parameter int LIMIT = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic inc,
   input  logic clr,
   output logic limit_hit
);

   localparam int CNT_W = $clog2(LIMIT + 1);
   localparam logic [CNT_W-1:0] LIMIT_V = CNT_W'(LIMIT);
   localparam logic [CNT_W-1:0] ONE_V   = CNT_W'(1);

   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_nxt_s;

   // Next count: clear has priority, increment stops at the limit.
   always_comb begin
      cnt_nxt_s = cnt_r;
      if (clr) begin
         cnt_nxt_s = {CNT_W{1'b0}};
      end else if (inc && (cnt_r < LIMIT_V)) begin
         cnt_nxt_s = cnt_r + ONE_V;
      end else begin
         cnt_nxt_s = cnt_r;
      end
   end

   // Count register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_r <= {CNT_W{1'b0}};
      end else begin
         cnt_r <= cnt_nxt_s;
      end
   end

   assign limit_hit = (cnt_r >= LIMIT_V);

endmodule

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
// Shares a single-ported data memory between the CPU load/store port and a
// host/debug port. The CPU has priority; a refused CPU access is signalled
// with cpu_stall and is re-presented by the CPU on the next cycle.
//
// Build option: define DMEM_ARB_STARVE_GUARD_EN to add the starvation
// guard, which forces a host slot once the host has waited STARVE_LIMIT
// cycles. Without it the host is served only in CPU-idle cycles and
// cpu_stall never rises.
//
// Ports:
//   clk, reset                  clock; async active-high reset
//   cpu_mem_read/_write         CPU access strobes
//   cpu_addr, cpu_wdata         CPU address / store data
//   cpu_rdata                   load data (mem_rdata passed straight through)
//   cpu_stall                   CPU access refused this cycle
//   host_req, host_we           host request (held until ack), 1 = write
//   host_addr, host_wdata       host address / write data
//   host_ack                    registered one-cycle completion pulse
//   host_rdata                  registered read data, held after the ack
//   mem_read, mem_write         memory strobes
//   mem_addr, mem_wdata         memory address / write data
//   mem_rdata                   combinational memory read data
// ---------------------------------------------------------------------------
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int ADDR_W       = DEF_ADDR_W,
   parameter int DATA_W       = DEF_DATA_W,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_mem_read,
   input  logic              cpu_mem_write,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_stall,
   input  logic              host_req,
   input  logic              host_we,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [DATA_W-1:0] host_wdata,
   output logic              host_ack,
   output logic [DATA_W-1:0] host_rdata,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   if (STARVE_LIMIT < 1) begin : g_bad_limit
      $error("dmem_arbiter: STARVE_LIMIT must be at least 1");
   end

   arb_state_e        state_r;
   arb_state_e        state_nxt_s;
   logic [DATA_W-1:0] host_rdata_r;

   logic cpu_act_s;
   logic ack_pend_s;
   logic host_ok_s;
   logic force_s;
   logic grant_host_s;

   // Request qualification. A request seen during its own ack cycle is the
   // tail of the previous transaction and must not start a new one.
   always_comb begin
      cpu_act_s    = cpu_mem_read | cpu_mem_write;
      ack_pend_s   = host_ack;
      host_ok_s    = host_req & ~ack_pend_s;
      grant_host_s = host_ok_s & (~cpu_act_s | force_s);
   end

`ifdef DMEM_ARB_STARVE_GUARD_EN
   logic wait_inc_s;
   logic wait_clr_s;
   logic limit_hit_s;

   // The count holds (neither inc nor clr) during the ack cycle.
   assign wait_inc_s = host_ok_s & ~grant_host_s;
   assign wait_clr_s = grant_host_s | ~host_req;
   assign force_s    = host_ok_s & limit_hit_s;

   dmem_arb_starve_cnt #(
      .LIMIT (STARVE_LIMIT)
   ) u_starve_cnt (
      .clk       (clk),
      .reset     (reset),
      .inc       (wait_inc_s),
      .clr       (wait_clr_s),
      .limit_hit (limit_hit_s)
   );
`else
   assign force_s = 1'b0;
`endif

   // Memory port steering; a refused CPU store is simply not forwarded.
   always_comb begin
      mem_read  = 1'b0;
      mem_write = 1'b0;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      cpu_stall = 1'b0;
      if (grant_host_s) begin
         mem_read  = ~host_we;
         mem_write = host_we;
         mem_addr  = host_addr;
         mem_wdata = host_wdata;
         cpu_stall = cpu_act_s;
      end else begin
         mem_read  = cpu_mem_read;
         mem_write = cpu_mem_write;
         mem_addr  = cpu_addr;
         mem_wdata = cpu_wdata;
         cpu_stall = 1'b0;
      end
   end

   assign cpu_rdata = mem_rdata;

   // FSM state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next state: a grant is always followed by exactly one ack cycle.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (grant_host_s) begin
               state_nxt_s = ACK;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         ACK:     state_nxt_s = IDLE;
         default: state_nxt_s = IDLE;
      endcase
   end

   // FSM outputs: ack is a pure decode of the state flop.
   always_comb begin
      host_ack = 1'b0;
      case (state_r)
         IDLE:    host_ack = 1'b0;
         ACK:     host_ack = 1'b1;
         default: host_ack = 1'b0;
      endcase
   end

   // Host read data capture at the end of a read grant cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         host_rdata_r <= {DATA_W{1'b0}};
      end else if (grant_host_s && !host_we) begin
         host_rdata_r <= mem_rdata;
      end else begin
         host_rdata_r <= host_rdata_r;
      end
   end

   assign host_rdata = host_rdata_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter
// Self-checking bench for dmem_arbiter with a behavioural data memory.
// Expectations follow the DMEM_ARB_STARVE_GUARD_EN build option.
// ---------------------------------------------------------------------------
module tb_dmem_arbiter;

   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int LIM = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          cpu_mem_read, cpu_mem_write;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_wdata, cpu_rdata;
   logic          cpu_stall;
   logic          host_req, host_we;
   logic [AW-1:0] host_addr;
   logic [DW-1:0] host_wdata;
   logic          host_ack;
   logic [DW-1:0] host_rdata;
   logic          mem_read, mem_write;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;

   logic          mem_init;
   logic [DW-1:0] mem_model [256];

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)) dut (
      .clk(clk), .reset(reset),
      .cpu_mem_read(cpu_mem_read), .cpu_mem_write(cpu_mem_write),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
      .cpu_stall(cpu_stall),
      .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
      .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata),
      .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   // Behavioural single-port memory: word i starts as 0x1000_0000 + i.
   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 256; i++) mem_model[i] <= 32'h1000_0000 + i;
      end else if (mem_write) begin
         mem_model[mem_addr[7:0]] <= mem_wdata;
      end
   end
   assign mem_rdata = mem_model[mem_addr[7:0]];

   typedef struct {
      logic        crd, cwr;
      logic [31:0] caddr, cwdata;
      logic        hreq, hwe;
      logic [31:0] haddr, hwdata;
      logic        e_stall, e_mrd, e_mwr;
      logic [31:0] e_maddr, e_mwdata;
      logic        e_ack;
      logic [31:0] e_crdata, e_hrdata;
   } vec_t;

   vec_t vecs [12];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %h, required %h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic crd, input logic cwr, input logic [31:0] ca,
                        input logic [31:0] cwd, input logic hr, input logic hw,
                        input logic [31:0] ha, input logic [31:0] hwd);
      cpu_mem_read  = crd;
      cpu_mem_write = cwr;
      cpu_addr      = ca;
      cpu_wdata     = cwd;
      host_req      = hr;
      host_we       = hw;
      host_addr     = ha;
      host_wdata    = hwd;
   endtask

   task automatic cyc_end();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // stimulus: crd cwr caddr cwdata hreq hwe haddr hwdata | stall mrd mwr maddr mwdata ack crdata hrdata
      vecs[0]  = '{1'b0,1'b0,32'h00,32'h0,    1'b0,1'b0,32'h00,32'h0,        1'b0,1'b0,1'b0,32'h00,32'h0,        1'b0,32'h1000_0000,32'h0};
      vecs[1]  = '{1'b1,1'b0,32'h10,32'h0,    1'b0,1'b0,32'h00,32'h0,        1'b0,1'b1,1'b0,32'h10,32'h0,        1'b0,32'h1000_0010,32'h0};
      vecs[2]  = '{1'b0,1'b1,32'h20,32'hAAAA, 1'b0,1'b0,32'h00,32'h0,        1'b0,1'b0,1'b1,32'h20,32'hAAAA,     1'b0,32'h1000_0020,32'h0};
      vecs[3]  = '{1'b0,1'b0,32'h00,32'h0,    1'b1,1'b1,32'h40,32'hDEADBEEF, 1'b0,1'b0,1'b1,32'h40,32'hDEADBEEF, 1'b0,32'h1000_0040,32'h0};
      vecs[4]  = '{1'b0,1'b0,32'h00,32'h0,    1'b0,1'b0,32'h00,32'h0,        1'b0,1'b0,1'b0,32'h00,32'h0,        1'b1,32'h1000_0000,32'h0};
      vecs[5]  = '{1'b0,1'b0,32'h00,32'h0,    1'b1,1'b0,32'h40,32'h0,        1'b0,1'b1,1'b0,32'h40,32'h0,        1'b0,32'hDEADBEEF, 32'h0};
      vecs[6]  = '{1'b0,1'b0,32'h00,32'h0,    1'b0,1'b0,32'h00,32'h0,        1'b0,1'b0,1'b0,32'h00,32'h0,        1'b1,32'h1000_0000,32'hDEADBEEF};
      vecs[7]  = '{1'b1,1'b0,32'h20,32'h0,    1'b1,1'b0,32'h30,32'h0,        1'b0,1'b1,1'b0,32'h20,32'h0,        1'b0,32'h0000_AAAA,32'hDEADBEEF};
      vecs[8]  = '{1'b0,1'b0,32'h00,32'h0,    1'b1,1'b0,32'h30,32'h0,        1'b0,1'b1,1'b0,32'h30,32'h0,        1'b0,32'h1000_0030,32'hDEADBEEF};
      vecs[9]  = '{1'b0,1'b0,32'h00,32'h0,    1'b1,1'b0,32'h30,32'h0,        1'b0,1'b0,1'b0,32'h00,32'h0,        1'b1,32'h1000_0000,32'h1000_0030};
      vecs[10] = '{1'b0,1'b0,32'h00,32'h0,    1'b1,1'b0,32'h30,32'h0,        1'b0,1'b1,1'b0,32'h30,32'h0,        1'b0,32'h1000_0030,32'h1000_0030};
      vecs[11] = '{1'b0,1'b1,32'h50,32'h5555, 1'b0,1'b0,32'h00,32'h0,        1'b0,1'b0,1'b1,32'h50,32'h5555,     1'b1,32'h1000_0050,32'h1000_0030};

      // Reset state
      reset    = 1'b1;
      mem_init = 1'b1;
      drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      #2;
      chk("reset host_ack",   {31'b0, host_ack},  32'h0);
      chk("reset host_rdata", host_rdata,         32'h0);
      chk("reset cpu_stall",  {31'b0, cpu_stall}, 32'h0);
      chk("reset mem_read",   {31'b0, mem_read},  32'h0);
      chk("reset mem_write",  {31'b0, mem_write}, 32'h0);
      cyc_end();
      cyc_end();
      reset    = 1'b0;
      mem_init = 1'b0;

      // Table-driven vectors, one per clock cycle
      for (int i = 0; i < 12; i++) begin
         drive(vecs[i].crd, vecs[i].cwr, vecs[i].caddr, vecs[i].cwdata,
               vecs[i].hreq, vecs[i].hwe, vecs[i].haddr, vecs[i].hwdata);
         @(negedge clk);
         chk($sformatf("row%0d cpu_stall", i),  {31'b0, cpu_stall}, {31'b0, vecs[i].e_stall});
         chk($sformatf("row%0d mem_read", i),   {31'b0, mem_read},  {31'b0, vecs[i].e_mrd});
         chk($sformatf("row%0d mem_write", i),  {31'b0, mem_write}, {31'b0, vecs[i].e_mwr});
         chk($sformatf("row%0d mem_addr", i),   mem_addr,           vecs[i].e_maddr);
         chk($sformatf("row%0d mem_wdata", i),  mem_wdata,          vecs[i].e_mwdata);
         chk($sformatf("row%0d host_ack", i),   {31'b0, host_ack},  {31'b0, vecs[i].e_ack});
         chk($sformatf("row%0d cpu_rdata", i),  cpu_rdata,          vecs[i].e_crdata);
         chk($sformatf("row%0d host_rdata", i), host_rdata,         vecs[i].e_hrdata);
         cyc_end();
      end

      // A: continuous CPU loads with a host read pending
`ifdef DMEM_ARB_STARVE_GUARD_EN
      for (int c = 1; c <= 5; c++) begin
         drive(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h60, 32'h0);
         @(negedge clk);
         chk($sformatf("A c%0d cpu_stall", c), {31'b0, cpu_stall}, (c == 5) ? 32'h1 : 32'h0);
         chk($sformatf("A c%0d mem_addr", c),  mem_addr,           (c == 5) ? 32'h60 : 32'h10);
         chk($sformatf("A c%0d host_ack", c),  {31'b0, host_ack},  32'h0);
         cyc_end();
      end
      drive(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      chk("A ack host_ack",   {31'b0, host_ack},  32'h1);
      chk("A ack cpu_stall",  {31'b0, cpu_stall}, 32'h0);
      chk("A ack cpu_rdata",  cpu_rdata,          32'h1000_0010);
      chk("A ack host_rdata", host_rdata,         32'h1000_0060);
      cyc_end();
`else
      for (int c = 1; c <= 8; c++) begin
         drive(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h60, 32'h0);
         @(negedge clk);
         chk($sformatf("A c%0d cpu_stall", c), {31'b0, cpu_stall}, 32'h0);
         chk($sformatf("A c%0d mem_addr", c),  mem_addr,           32'h10);
         chk($sformatf("A c%0d host_ack", c),  {31'b0, host_ack},  32'h0);
         cyc_end();
      end
      drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h60, 32'h0);
      @(negedge clk);
      chk("A idle mem_read", {31'b0, mem_read}, 32'h1);
      chk("A idle mem_addr", mem_addr,          32'h60);
      cyc_end();
      drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      chk("A ack host_ack",   {31'b0, host_ack}, 32'h1);
      chk("A ack host_rdata", host_rdata,        32'h1000_0060);
      cyc_end();
`endif
      drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      cyc_end();

      // B: CPU store and host write to the same word collide
      for (int c = 1; c <= 4; c++) begin
         drive(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b1, 32'h80, 32'h22);
         @(negedge clk);
         chk($sformatf("B c%0d mem_write", c), {31'b0, mem_write}, 32'h0);
         cyc_end();
      end
      drive(1'b0, 1'b1, 32'h80, 32'h11, 1'b1, 1'b1, 32'h80, 32'h22);
      @(negedge clk);
`ifdef DMEM_ARB_STARVE_GUARD_EN
      chk("B force cpu_stall", {31'b0, cpu_stall}, 32'h1);
      chk("B force mem_wdata", mem_wdata,          32'h22);
      cyc_end();
      drive(1'b0, 1'b1, 32'h80, 32'h11, 1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      chk("B retry host_ack",  {31'b0, host_ack},  32'h1);
      chk("B retry cpu_stall", {31'b0, cpu_stall}, 32'h0);
      chk("B mem after host",  mem_model[8'h80],   32'h22);
      cyc_end();
      drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      chk("B mem after cpu", mem_model[8'h80], 32'h11);
      cyc_end();
`else
      chk("B cpu cpu_stall", {31'b0, cpu_stall}, 32'h0);
      chk("B cpu mem_wdata", mem_wdata,          32'h11);
      cyc_end();
      drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h80, 32'h22);
      @(negedge clk);
      chk("B host mem_wdata", mem_wdata,        32'h22);
      chk("B mem after cpu",  mem_model[8'h80], 32'h11);
      cyc_end();
      drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      chk("B host_ack",        {31'b0, host_ack}, 32'h1);
      chk("B mem after host",  mem_model[8'h80], 32'h22);
      cyc_end();
`endif

      // C: reset asserted in the ack cycle
      drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0);
      @(negedge clk);
      chk("C grant mem_read", {31'b0, mem_read}, 32'h1);
      cyc_end();
      drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      chk("C host_ack",   {31'b0, host_ack}, 32'h1);
      chk("C host_rdata", host_rdata,        32'hDEADBEEF);
      #1 reset = 1'b1;
      #1;
      chk("C reset host_ack",   {31'b0, host_ack}, 32'h0);
      chk("C reset host_rdata", host_rdata,        32'h0);
      cyc_end();
      reset = 1'b0;
      drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0);
      @(negedge clk);
      chk("C post-reset grant", {31'b0, mem_read}, 32'h1);
      cyc_end();
      drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      chk("C post-reset ack",    {31'b0, host_ack}, 32'h1);
      chk("C committed survive", host_rdata,        32'hDEADBEEF);
      cyc_end();

`ifdef DMEM_ARB_STARVE_GUARD_EN
      // D: reset clears a partially built wait count
      for (int c = 1; c <= 3; c++) begin
         drive(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h60, 32'h0);
         @(negedge clk);
         chk($sformatf("D pre c%0d cpu_stall", c), {31'b0, cpu_stall}, 32'h0);
         if (c < 3) cyc_end();
      end
      #1 reset = 1'b1;
      cyc_end();
      reset = 1'b0;
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         chk($sformatf("D post c%0d cpu_stall", c), {31'b0, cpu_stall}, (c == 5) ? 32'h1 : 32'h0);
         cyc_end();
      end
      drive(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      chk("D host_ack", {31'b0, host_ack}, 32'h1);
      cyc_end();
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
